// File: rtl/uart_rx_pkg.sv
// Shared 8N1 UART definitions: frame constants, receiver states, bit period helper.
package uart_rx_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        RCV_START_BIT,
        RCV_DATA_BITS,
        RCV_STOP_BIT,
        WAIT_IDLE
    } state_t;

    function automatic int bit_period(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and 1-cycle valid/error strobes.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling of every bit.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD_RATE    = 9_600,
    parameter int SYS_CLK_FREQ = 48_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int BIT_PERIOD = bit_period(SYS_CLK_FREQ, BAUD_RATE);
    localparam int HALF       = BIT_PERIOD / 2;
    localparam int TW         = $clog2(BIT_PERIOD);

    localparam logic [TW-1:0] T_FULL = TW'(BIT_PERIOD - 1);
    localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [2:0]    bit_index, index_next;
    logic [7:0]    shift, shift_next;
    logic [7:0]    out_next;
    logic          valid_next, ferr_next, busy_next;
    logic          rx_s, bit_val, timer_zero;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign timer_zero = (timer == '0);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] early;

    // Early samples at timer==2 and timer==1 join the timer==0 sample in a vote
    always_ff @(posedge clk) begin
        if (reset) begin
            early <= 2'b11;
        end else if (timer == TW'(2)) begin
            early[1] <= rx_s;
        end else if (timer == TW'(1)) begin
            early[0] <= rx_s;
        end
    end

    assign bit_val = (early[1] & early[0]) | (early[1] & rx_s) | (early[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            bit_index   <= '0;
            shift       <= '0;
            data_out    <= 8'h00;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            bit_index   <= index_next;
            shift       <= shift_next;
            data_out    <= out_next;
            data_valid  <= valid_next;
            frame_error <= ferr_next;
            busy        <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer_zero ? timer : timer - 1'b1;
        index_next = bit_index;
        shift_next = shift;
        out_next   = data_out;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        busy_next  = busy;
        unique case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (!rx_s) begin
                    timer_next = T_HALF;
                    busy_next  = 1'b1;
                    state_next = RCV_START_BIT;
                end
            end
            RCV_START_BIT: begin
                if (timer_zero) begin
                    if (!bit_val) begin
                        timer_next = T_FULL;
                        index_next = '0;
                        state_next = RCV_DATA_BITS;
                    end else begin
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            RCV_DATA_BITS: begin
                if (timer_zero) begin
                    shift_next = {bit_val, shift[7:1]};
                    timer_next = T_FULL;
                    index_next = bit_index + 3'd1;
                    if (bit_index == 3'(DATA_BITS - 1)) begin
                        state_next = RCV_STOP_BIT;
                    end
                end
            end
            RCV_STOP_BIT: begin
                if (timer_zero) begin
                    if (bit_val) begin
                        out_next   = shift;
                        valid_next = 1'b1;
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // A held-low break must not look like a fresh start bit
                if (rx_s) begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random byte stream.
module tb_uart_rx;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int BP     = CLK_HZ / BAUD;
    localparam int HALF   = BP / 2;
    localparam int LAT    = 3 + HALF + 9 * BP;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    uart_rx #(
        .BAUD_RATE    (BAUD),
        .SYS_CLK_FREQ (CLK_HZ)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] dv_q[$];
    int         dv_t[$];
    int         fe_t[$];
    int         busy_cnt;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_q.push_back(data_out);
            dv_t.push_back(cyc);
        end
        if (frame_error) fe_t.push_back(cyc);
        if (busy) busy_cnt++;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        dv_q.delete();
        dv_t.delete();
        fe_t.delete();
        busy_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    // Drives ncyc cycles of a frame; level beyond bit 9 stays at the stop level.
    // glitch is a cycle index forced high (-1 for none). e = index of edge E.
    task automatic drive_frame(input logic [7:0] d, input logic stop,
                               input int glitch, input int ncyc, output int e);
        logic [9:0] bits;
        int k;
        bits = {stop, d, 1'b0};
        e = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (i == 0) e = cyc + 1;
            k = i / BP;
            if (k > 9) k = 9;
            rx = (i == glitch) ? 1'b1 : bits[k];
        end
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] rb;
    int e1, e2;

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_valid", data_valid, 0);
        chk("rst_ferr", frame_error, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        idle(20);

        clear_mon();
        drive_frame(8'hA5, 1'b1, -1, 10 * BP, e1);
        idle(20);
        chk("t1_count", dv_q.size(), 1);
        chk("t1_data", dv_q[0], 8'hA5);
        chk("t1_latency", dv_t[0] - e1 + 1, LAT);
        chk("t1_ferr", fe_t.size(), 0);
        chk("t1_hold", data_out, 8'hA5);

        clear_mon();
        drive_frame(8'h00, 1'b1, -1, 10 * BP, e1);
        drive_frame(8'hFF, 1'b1, -1, 10 * BP, e2);
        idle(20);
        chk("t2_count", dv_q.size(), 2);
        chk("t2_first", dv_q[0], 8'h00);
        chk("t2_second", dv_q[1], 8'hFF);
        chk("t2_spacing", dv_t[1] - dv_t[0], 10 * BP);
        chk("t2_latency", dv_t[0] - e1 + 1, LAT);

        clear_mon();
        repeat (3) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle(25);
        chk("t3_valid", dv_q.size(), 0);
        chk("t3_ferr", fe_t.size(), 0);
        chk("t3_busy_seen", busy_cnt > 0, 1);
        chk("t3_busy_short", busy_cnt <= 9, 1);
        chk("t3_busy_end", busy, 0);
        chk("t3_data_out", data_out, 8'hFF);

        clear_mon();
        drive_frame(8'h55, 1'b0, -1, 10 * BP + 30, e1);
        chk("t4_busy_held", busy, 1);
        chk("t4_ferr_count", fe_t.size(), 1);
        chk("t4_ferr_latency", fe_t[0] - e1 + 1, LAT);
        chk("t4_valid", dv_q.size(), 0);
        chk("t4_data_out", data_out, 8'hFF);
        idle(6);
        chk("t4_busy_release", busy, 0);
        chk("t4_ferr_once", fe_t.size(), 1);
        idle(20);

        clear_mon();
        drive_frame(8'h3C, 1'b1, -1, 5 * BP + HALF, e1);
        @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        chk("t5_rst_data", data_out, 8'h00);
        chk("t5_rst_valid", data_valid, 0);
        chk("t5_rst_ferr", frame_error, 0);
        chk("t5_rst_busy", busy, 0);
        reset = 1'b0;
        idle(20);
        chk("t5_no_strobe", dv_q.size() + fe_t.size(), 0);
        drive_frame(8'h3C, 1'b1, -1, 10 * BP, e1);
        idle(20);
        chk("t5_count", dv_q.size(), 1);
        chk("t5_data", data_out, 8'h3C);

        clear_mon();
        drive_frame(8'h00, 1'b1, HALF + 3 * BP, 10 * BP, e1);
        idle(20);
        chk("t6_count", dv_q.size(), 1);
`ifdef UART_RX_MAJORITY_EN
        chk("t6_data", data_out, 8'h00);
`else
        chk("t6_data", data_out, 8'h04);
`endif

        clear_mon();
        exp_q.delete();
        for (int n = 0; n < 8; n++) begin
            rb = 8'($urandom_range(0, 255));
            exp_q.push_back(rb);
            drive_frame(rb, 1'b1, -1, 10 * BP, e1);
            idle($urandom_range(0, 15));
        end
        idle(20);
        chk("rand_count", dv_q.size(), exp_q.size());
        for (int n = 0; n < 8; n++) begin
            chk($sformatf("rand_byte%0d", n), dv_q[n], exp_q[n]);
        end
        chk("rand_ferr", fe_t.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
